// File: rtl/trivia_block_feeder.sv
// Input-side block feeder for the TriviA controller: buffers AD/message words
// in a small FIFO and returns one 10*-padded 64-bit block per block request.
module trivia_block_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] adlen,
  input  logic [63:0] msglen,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        blk_req,
  output logic [63:0] blk_data,
  output logic        blk_valid,
  output logic        blk_final,
  output logic        phase,
  output logic        underrun,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_AD, ST_MSG, ST_DONE} state_t;

  state_t      r_state;
  logic [63:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic [63:0] r_in_ad, r_in_msg, r_out_ad, r_out_msg;
  logic [63:0] r_blk_data;
  logic        r_blk_valid, r_blk_final, r_phase, r_underrun, r_done;

  logic        w_full, w_empty, w_active, w_push, w_pop, w_last, w_start;
  logic [63:0] w_rem, w_rem_next;

  // Input words needed for a phase; an empty phase still consumes one word.
  function automatic logic [63:0] word_count(input logic [63:0] len);
    if (len == 64'd0) return 64'd1;
    return (len >> 3) + {63'd0, |len[2:0]};
  endfunction

  // Keep the first r bytes, place 0x80 at byte r, zero the rest (r < 8).
  function automatic logic [63:0] pad_block(input logic [63:0] w, input logic [63:0] r);
    logic [5:0]  sh;
    logic [63:0] keep;
    if (r >= 64'd8) return w;
    sh   = {r[2:0], 3'b000};
    keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
    return (w & keep) | (64'h80 << (6'd56 - sh));
  endfunction

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_active   = (r_state == ST_AD) | (r_state == ST_MSG);
  assign s_ready    = ~w_full & ((r_in_ad != 64'd0) | (r_in_msg != 64'd0));
  assign w_push     = s_valid & s_ready;
  assign w_pop      = blk_req & w_active & ~w_empty;
  assign w_start    = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_rem      = (r_state == ST_MSG) ? r_out_msg : r_out_ad;
  assign w_last     = (w_rem <= 64'd8);
  assign w_rem_next = (w_rem >= 64'd8) ? (w_rem - 64'd8) : 64'd0;

  assign blk_data  = r_blk_data;
  assign blk_valid = r_blk_valid;
  assign blk_final = r_blk_final;
  assign phase     = r_phase;
  assign underrun  = r_underrun;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_in_ad     <= 64'd0;
      r_in_msg    <= 64'd0;
      r_out_ad    <= 64'd0;
      r_out_msg   <= 64'd0;
      r_blk_data  <= 64'd0;
      r_blk_valid <= 1'b0;
      r_blk_final <= 1'b0;
      r_phase     <= 1'b0;
      r_underrun  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_blk_valid <= 1'b0;
      r_blk_final <= 1'b0;

      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_in_ad != 64'd0) r_in_ad  <= r_in_ad - 64'd1;
        else                  r_in_msg <= r_in_msg - 64'd1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_rptr      <= r_rptr + 1'b1;
        r_blk_data  <= pad_block(r_mem[r_rptr], w_rem);
        r_blk_valid <= 1'b1;
        r_blk_final <= w_last;
        if (r_state == ST_MSG) r_out_msg <= w_rem_next;
        else                   r_out_ad  <= w_rem_next;
        if (w_last) begin
          if (r_state == ST_AD) begin
            r_state <= ST_MSG;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
      end

      if (blk_req & w_active & w_empty) r_underrun <= 1'b1;

      // phase trails the state change by one cycle, landing after blk_final
      if (r_state == ST_MSG) r_phase <= 1'b1;

      if (w_start) begin
        r_in_ad    <= word_count(adlen);
        r_in_msg   <= word_count(msglen);
        r_out_ad   <= adlen;
        r_out_msg  <= msglen;
        r_done     <= 1'b0;
        r_underrun <= 1'b0;
        r_phase    <= 1'b0;
        r_state    <= ST_AD;
      end
    end
  end

endmodule
